// File: rtl/vend_pkg.sv
// vend_pkg: shared coin codes, prices and scheduler state encoding
package vend_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1 = 2'b01;
  localparam logic [1:0] COIN_2 = 2'b10;
  localparam logic [1:0] COIN_5 = 2'b11;
  localparam int DRINK_PRICE = 5;
  localparam int CHOC_PRICE = 3;
  typedef enum logic [1:0] {IDLE, START, VEND, RESP} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from last_owner+1 with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int OW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [OW-1:0] last_owner,
  output logic [N-1:0]  grant
);
  logic [OW-1:0] idx;
  // Scan farthest offset first so the nearest eligible panel overwrites the rest
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = OW'((int'(last_owner) + k) % N);
      if (eligible[idx]) grant = N'(1) << idx;
    end
  end
endmodule

// File: rtl/vend_scheduler.sv
// vend_scheduler: arbitrates customer panels onto one vending core and tracks stock
module vend_scheduler
  import vend_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int STOCK_W = 4,
  parameter int DRINK_INIT = 8,
  parameter int CHOC_INIT = 8,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_sel,
  input  logic [2*N_REQ-1:0] req_coin,
  input  logic               refill,
  input  logic               refill_sel,
  input  logic [STOCK_W-1:0] refill_cnt,
  output logic               core_start,
  output logic               core_sel,
  output logic [1:0]         core_coin,
  output logic               core_rst,
  input  logic               core_product,
  input  logic [3:0]         core_change,
  input  logic               core_done,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   soldout,
  output logic               resp_product,
  output logic [3:0]         resp_change,
  output logic               resp_timeout,
  output logic               busy,
  output logic [STOCK_W-1:0] drink_stock,
  output logic [STOCK_W-1:0] choc_stock
);
  localparam int OW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  sched_state_t state, nxt;
  logic [N_REQ-1:0] avail, eligible, rr_gnt;
  logic [OW-1:0] owner, last_owner, gidx;
  logic prod;
  logic [WW-1:0] wd;
  logic expired, vend_end, idle_refill;
  assign eligible = req & avail;
  assign expired = state == VEND && !core_done && wd == WW'(TIMEOUT - 1);
  assign vend_end = state == VEND && (core_done || wd == WW'(TIMEOUT - 1));
  assign idle_refill = refill && state == IDLE;
  rr_arbiter #(.N(N_REQ), .OW(OW)) u_arb (
    .eligible(eligible),
    .last_owner(last_owner),
    .grant(rr_gnt)
  );
  // Per-panel stock availability for its chosen product, and index of the arbiter pick
  always_comb begin
    avail = '0;
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      avail[i] = (req_sel[i] ? drink_stock : choc_stock) != '0;
      if (rr_gnt[i]) gidx = OW'(i);
    end
  end
  // Next-state: grant leaves IDLE, done or watchdog leaves VEND
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (|eligible ? START : IDLE) :
          state == START ? VEND :
          state == VEND ? (vend_end ? RESP : VEND) : IDLE;
  end
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // Registered outputs, ownership, watchdog and stock counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt <= '0;
      ack <= '0;
      soldout <= '0;
      core_start <= 1'b0;
      core_sel <= 1'b0;
      core_coin <= COIN_NONE;
      core_rst <= 1'b0;
      resp_product <= 1'b0;
      resp_change <= '0;
      resp_timeout <= 1'b0;
      busy <= 1'b0;
      owner <= '0;
      last_owner <= OW'(N_REQ - 1);
      prod <= 1'b0;
      wd <= '0;
      drink_stock <= STOCK_W'(DRINK_INIT);
      choc_stock <= STOCK_W'(CHOC_INIT);
    end else begin
      busy <= nxt != IDLE;
      core_start <= state == START;
      core_sel <= state == START && prod;
      core_coin <= nxt == VEND ? req_coin[2*owner +: 2] : COIN_NONE;
      core_rst <= expired;
      soldout <= state == IDLE ? req & ~avail : '0;
      ack <= vend_end ? N_REQ'(1) << owner : '0;
      wd <= state == START ? '0 : state == VEND ? wd + 1'b1 : wd;
      if (state == IDLE && |eligible) begin
        gnt <= rr_gnt;
        owner <= gidx;
        prod <= req_sel[gidx];
      end
      if (state == RESP) begin
        gnt <= '0;
        last_owner <= owner;
      end
      if (vend_end) begin
        resp_timeout <= !core_done;
        resp_product <= core_done && core_product;
        resp_change <= core_done ? core_change : 4'd0;
      end
      drink_stock <= idle_refill && refill_sel ? refill_cnt :
                     state == VEND && core_done && prod && drink_stock != '0 ? drink_stock - 1'b1 : drink_stock;
      choc_stock <= idle_refill && !refill_sel ? refill_cnt :
                    state == VEND && core_done && !prod && choc_stock != '0 ? choc_stock - 1'b1 : choc_stock;
    end
  end
endmodule

// File: tb/tb_vend_scheduler.sv
// tb_vend_scheduler: directed vector table plus hand-written multi-cycle sequences
module tb_vend_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0, req_sel = '0;
  logic [7:0] req_coin = '0;
  logic refill = 1'b0, refill_sel = 1'b0;
  logic [3:0] refill_cnt = '0;
  logic core_start, core_sel, core_rst;
  logic [1:0] core_coin;
  logic core_product = 1'b0, core_done = 1'b0;
  logic [3:0] core_change = '0;
  logic [3:0] gnt, ack, soldout;
  logic resp_product, resp_timeout, busy;
  logic [3:0] resp_change, drink_stock, choc_stock;
  int checks = 0, failures = 0;

  vend_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel), .req_coin(req_coin),
    .refill(refill), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
    .core_start(core_start), .core_sel(core_sel), .core_coin(core_coin), .core_rst(core_rst),
    .core_product(core_product), .core_change(core_change), .core_done(core_done),
    .gnt(gnt), .ack(ack), .soldout(soldout), .resp_product(resp_product),
    .resp_change(resp_change), .resp_timeout(resp_timeout), .busy(busy),
    .drink_stock(drink_stock), .choc_stock(choc_stock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] sel;
    logic [7:0] coin;
    logic done;
    logic [3:0] chg;
    logic prod;
    logic [3:0] e_gnt;
    logic e_start;
    logic [3:0] e_ack;
    logic [1:0] e_coin;
    logic [3:0] e_drink;
    logic e_busy;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [3:0] exp);
    int n = 0;
    while (gnt == 4'b0 && n < 20) begin
      step();
      n++;
    end
    chk("gnt_wait", gnt, exp);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b0001, 4'b0001, 8'h00, 1'b0, 4'd0, 1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, 4'd8, 1'b1};
    vecs[1] = '{4'b0001, 4'b0001, 8'h02, 1'b0, 4'd0, 1'b0, 4'b0001, 1'b1, 4'b0000, 2'd2, 4'd8, 1'b1};
    vecs[2] = '{4'b0001, 4'b0001, 8'hF2, 1'b0, 4'd0, 1'b0, 4'b0001, 1'b0, 4'b0000, 2'd2, 4'd8, 1'b1};
    vecs[3] = '{4'b0001, 4'b0001, 8'hA1, 1'b0, 4'd0, 1'b0, 4'b0001, 1'b0, 4'b0000, 2'd1, 4'd8, 1'b1};
    vecs[4] = '{4'b0001, 4'b0001, 8'h00, 1'b1, 4'd0, 1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 4'd7, 1'b1};
    vecs[5] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'd7, 1'b0};
    step();
    step();
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drink", drink_stock, 4'd8);
    chk("rst_choc", choc_stock, 4'd8);
    chk("rst_coin", core_coin, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      req = vecs[i].req;
      req_sel = vecs[i].sel;
      req_coin = vecs[i].coin;
      core_done = vecs[i].done;
      core_change = vecs[i].chg;
      core_product = vecs[i].prod;
      step();
      chk($sformatf("v%0d_gnt", i), gnt, vecs[i].e_gnt);
      chk($sformatf("v%0d_start", i), core_start, vecs[i].e_start);
      chk($sformatf("v%0d_ack", i), ack, vecs[i].e_ack);
      chk($sformatf("v%0d_coin", i), core_coin, vecs[i].e_coin);
      chk($sformatf("v%0d_drink", i), drink_stock, vecs[i].e_drink);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
    end
    chk("v_resp_product", resp_product, 1'b1);
    chk("v_resp_change", resp_change, 4'd0);
    chk("v_resp_timeout", resp_timeout, 1'b0);

    pulse_rst();
    req = 4'b1111;
    req_sel = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(4'b0001 << k);
      step();
      chk($sformatf("rr%0d_start", k), core_start, 1'b1);
      chk($sformatf("rr%0d_sel", k), core_sel, 1'b0);
      step();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      chk($sformatf("rr%0d_ack", k), ack, 4'b0001 << k);
      if (k == 3) req = 4'b0000;
      step();
    end
    chk("rr_choc", choc_stock, 4'd4);

    refill = 1'b1;
    refill_sel = 1'b0;
    refill_cnt = 4'd0;
    step();
    refill = 1'b0;
    chk("refill_choc0", choc_stock, 4'd0);
    req = 4'b0100;
    req_sel = 4'b0000;
    step();
    chk("so_pulse", soldout, 4'b0100);
    chk("so_gnt", gnt, 4'b0);
    chk("so_busy", busy, 1'b0);
    req = 4'b0000;
    step();
    chk("so_clear", soldout, 4'b0);

    req = 4'b0001;
    req_sel = 4'b0001;
    wait_gnt(4'b0001);
    step();
    chk("to_start", core_start, 1'b1);
    for (int c = 0; c < 199; c++) step();
    chk("to_early", core_rst, 1'b0);
    step();
    chk("to_core_rst", core_rst, 1'b1);
    chk("to_ack", ack, 4'b0001);
    chk("to_flag", resp_timeout, 1'b1);
    chk("to_change", resp_change, 4'd0);
    chk("to_drink", drink_stock, 4'd8);
    req = 4'b0000;
    step();
    chk("to_rst_clear", core_rst, 1'b0);

    req = 4'b0001;
    wait_gnt(4'b0001);
    step();
    step();
    refill = 1'b1;
    refill_sel = 1'b1;
    refill_cnt = 4'd15;
    step();
    refill = 1'b0;
    chk("rf_vend_ignored", drink_stock, 4'd8);
    core_done = 1'b1;
    core_change = 4'd3;
    step();
    core_done = 1'b0;
    chk("rf_ack", ack, 4'b0001);
    chk("rf_change", resp_change, 4'd3);
    chk("rf_drink_dec", drink_stock, 4'd7);
    req = 4'b0000;
    step();
    refill = 1'b1;
    step();
    refill = 1'b0;
    chk("rf_idle_load", drink_stock, 4'd15);

    req = 4'b0010;
    req_sel = 4'b0000;
    req_coin = 8'b0000_1100;
    refill_sel = 1'b0;
    refill_cnt = 4'd5;
    refill = 1'b1;
    step();
    refill = 1'b0;
    chk("rf_pri_choc", choc_stock, 4'd5);
    chk("rf_pri_nogrant", gnt, 4'b0);
    chk("rf_pri_soldout", soldout, 4'b0010);
    wait_gnt(4'b0010);
    step();
    step();
    chk("rm_coin", core_coin, 2'd3);
    rst = 1'b1;
    #1;
    chk("rm_gnt", gnt, 4'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_coin_clr", core_coin, 2'd0);
    chk("rm_ack", ack, 4'b0);
    chk("rm_drink", drink_stock, 4'd8);
    chk("rm_choc", choc_stock, 4'd8);
    chk("rm_start", core_start, 1'b0);
    chk("rm_timeout", resp_timeout, 1'b0);
    req = 4'b0000;
    step();
    rst = 1'b0;
    step();
    chk("rm_after_ack", ack, 4'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vend_scheduler.md
VEND_SCHEDULER -- requirements
Module: vend_scheduler

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- N_REQ, 4, number of customer panels
- STOCK_W, 4, stock counter width
- DRINK_INIT, 8, drink stock after reset
- CHOC_INIT, 8, chocolate stock after reset
- TIMEOUT, 200, max VEND cycles before abort
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous active-high reset
- req, in, N_REQ, panel i requests a vend, level, held until ack[i] or soldout[i]
- req_sel, in, N_REQ, per-panel product: 1=drink, 0=chocolate
- req_coin, in, 2*N_REQ, per-panel coin code (00 none, 01=1, 10=2, 11=5)
- refill, in, 1, one-cycle stock load strobe
- refill_sel, in, 1, 1=drink counter, 0=chocolate counter
- refill_cnt, in, STOCK_W, value loaded
- core_start, out, 1, start pulse to vending core
- core_sel, out, 1, product select to core
- core_coin, out, 2, coin forwarded from granted panel
- core_rst, out, 1, one-cycle core reset on timeout
- core_product, in, 1, core product output
- core_change, in, 4, core change output
- core_done, in, 1, core completion pulse
- gnt, out, N_REQ, one-hot owner, 0 in IDLE
- ack, out, N_REQ, one-cycle completion pulse to owner
- soldout, out, N_REQ, one-cycle reject, requested product stock 0
- resp_product, out, 1, product delivered; valid with ack
- resp_change, out, 4, change; valid with ack
- resp_timeout, out, 1, vend aborted; valid with ack
- busy, out, 1, high in any state but IDLE
- drink_stock, out, STOCK_W, current drink count
- choc_stock, out, STOCK_W, current chocolate count

Function
REQ-003 FSM states SHALL be IDLE, START, VEND, RESP; all outputs registered.
REQ-004 IDLE: eligible[i] = req[i] AND stock(req_sel[i]) != 0. Any eligible panel SHALL be granted round-robin, searching from last_owner+1 upward with wrap. The grant SHALL latch owner index and product, then move to START.
REQ-005 IDLE: for each req[i] with stock(req_sel[i]) == 0, soldout[i] SHALL pulse next cycle. No grant or state change for that panel.
REQ-006 START: core_start=1 and core_sel=latched product for exactly one cycle, then VEND.
REQ-007 VEND: core_coin SHALL equal req_coin of the owner each cycle; non-owner coins ignored; core_coin=00 outside VEND.
REQ-008 VEND on core_done: capture core_product/core_change, decrement latched product stock by 1, go RESP.
REQ-009 VEND watchdog: counter cleared on START. When it reaches TIMEOUT without core_done: core_rst=1 for one cycle, resp_timeout=1, resp_change=0, no stock change, go RESP.
REQ-010 RESP: ack[owner]=1 one cycle; resp_* held until next ack; last_owner=owner; next state IDLE; gnt cleared.
REQ-011 Latency SHALL be: req seen in IDLE -> gnt next cycle; core_start the cycle after; ack exactly 1 cycle after core_done sampled.
REQ-012 refill SHALL load refill_cnt into the selected counter only in IDLE. In other states it is ignored. It takes priority over a same-cycle grant decision, which uses pre-refill stock.
REQ-013 Stock SHALL never underflow; grant is impossible at 0. core_done with latched stock 0 leaves it 0.
REQ-014 req deassertion by the owner mid-vend SHALL NOT abort; the vend completes and acks.

Reset
REQ-015 rst SHALL force: state IDLE, gnt/ack/soldout/core_start/core_rst/resp_*=0, core_coin=00, last_owner=N_REQ-1 (panel 0 first), drink_stock=DRINK_INIT, choc_stock=CHOC_INIT, watchdog=0.
REQ-016 Reset mid-vend SHALL drop the transaction with no ack and no stock change.

Structure
REQ-017 Shared package vend_pkg SHALL hold coin codes, DRINK_PRICE=5, CHOC_PRICE=3, and the scheduler state enum.
REQ-018 Round-robin selection SHALL be a sub-module rr_arbiter (inputs eligible and last_owner, output one-hot grant).

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- Reset, req=0001, sel=1, coins 2,2,1, core_done with change 0 -> gnt=0001, core_start once, ack[0], drink_stock 8->7.
- req=1111 held over four vends -> grant order 0,1,2,3.
- choc_stock refilled to 0, req[2] with sel=0 -> soldout[2] pulse, no gnt, busy=0.
- Vend with no core_done, TIMEOUT=200 -> core_rst at VEND cycle 200, ack with resp_timeout=1, stock unchanged.
- refill during VEND ignored; same refill in IDLE loads 15 -> drink_stock=15.
- rst asserted in VEND -> all outputs reset values, stocks = INIT.
